// File: rtl/data_ram_pkg.sv
// Shared types and address-map helpers for the memory-mapped data RAM / pin block.
// Region bases are functions so every user derives them from the same pin counts.
package data_ram_pkg;

  typedef enum logic [1:0] {REG_OUT, REG_LVL, REG_EDG, REG_MEM} region_t;

  function automatic int unsigned lvl_base(int unsigned n_out);
    return n_out;
  endfunction

  function automatic int unsigned edg_base(int unsigned n_out, int unsigned n_in);
    return n_out + n_in;
  endfunction

  function automatic int unsigned mem_base(int unsigned n_out, int unsigned n_in);
    return n_out + 2 * n_in;
  endfunction

  function automatic region_t decode_region(int unsigned address, int unsigned n_out,
                                            int unsigned n_in);
    if (address < lvl_base(n_out)) return REG_OUT;
    if (address < edg_base(n_out, n_in)) return REG_LVL;
    if (address < mem_base(n_out, n_in)) return REG_EDG;
    return REG_MEM;
  endfunction

endpackage

// File: rtl/data_ram_mmio_if.sv
// ICU-side data bus of the data RAM: strobes, address and both data directions.
interface data_ram_mmio_if #(
  parameter int unsigned WORD     = 1,
  parameter int unsigned SIZE_LOG = 8
);
  logic                write;
  logic                read;
  logic [SIZE_LOG-1:0] address;
  logic [WORD-1:0]     data_in;
  logic [WORD-1:0]     data_out;

  modport master (output write, read, address, data_in, input data_out);
  modport slave  (input write, read, address, data_in, output data_out);
endinterface

// File: rtl/input_sync_edge.sv
// One input pin: synchroniser chain, edge-detect flop and sticky rising-edge flag.
module input_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic clear,
  output logic level,
  output logic flag
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   flag_q, flag_d;
  logic                   rise;

  assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
  // A new edge beats a same-cycle clear so no event is lost.
  assign flag_d = rise | (flag_q & ~clear);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      flag_q <= flag_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign flag  = flag_q;
endmodule

// File: rtl/data_ram_mmio.sv
// Data RAM with output pins, synchronised input levels and edge flags in one address space.
// Reads are registered (1-cycle latency); a simultaneous write wins and data_out holds.
module data_ram_mmio
  import data_ram_pkg::*;
#(
  parameter int unsigned WORD        = 1,
  parameter int unsigned SIZE_LOG    = 8,
  parameter int unsigned OUTPUT      = 5,
  parameter int unsigned INPUT       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  data_ram_mmio_if.slave          bus,
  input  logic [INPUT-1:0]        input_pins,
  output logic [OUTPUT-1:0]       output_pins
);
  localparam int unsigned SIZE     = 2 ** SIZE_LOG;
  localparam int unsigned LVL_BASE = lvl_base(OUTPUT);
  localparam int unsigned EDG_BASE = edg_base(OUTPUT, INPUT);

  if (SIZE < OUTPUT + 2 * INPUT) begin : g_size_check
    $error("data_ram_mmio: SIZE too small for OUTPUT + 2*INPUT");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("data_ram_mmio: SYNC_STAGES must be >= 2");
  end

  logic            read_en;
  region_t         region;
  logic [WORD-1:0] rdata;
  logic [WORD-1:0] data_out_d, data_out_q;
  logic [OUTPUT-1:0] out_d, out_q;
  logic [INPUT-1:0]  level, flag, flag_clr;
  logic [WORD-1:0]   mem [SIZE];

  assign read_en = bus.read & ~bus.write;
  assign region  = decode_region(32'(bus.address), OUTPUT, INPUT);

  for (genvar i = 0; i < INPUT; i++) begin : g_pin
    // Cleared by a plain read (clear-on-read) or by writing a 1.
    assign flag_clr[i] = (bus.address == SIZE_LOG'(EDG_BASE + i)) &&
                         (read_en || (bus.write && bus.data_in[0]));

    input_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .pin   (input_pins[i]),
      .clear (flag_clr[i]),
      .level (level[i]),
      .flag  (flag[i])
    );
  end

  always_comb begin
    out_d = out_q;
    if (bus.write) begin
      for (int unsigned i = 0; i < OUTPUT; i++) begin
        if (bus.address == SIZE_LOG'(i)) out_d[i] = bus.data_in[0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (region)
      REG_OUT: begin
        for (int unsigned i = 0; i < OUTPUT; i++) begin
          if (bus.address == SIZE_LOG'(i)) rdata[0] = out_q[i];
        end
      end
      REG_LVL: begin
        for (int unsigned i = 0; i < INPUT; i++) begin
          if (bus.address == SIZE_LOG'(LVL_BASE + i)) rdata[0] = level[i];
        end
      end
      REG_EDG: begin
        for (int unsigned i = 0; i < INPUT; i++) begin
          if (bus.address == SIZE_LOG'(EDG_BASE + i)) rdata[0] = flag[i];
        end
      end
      REG_MEM: rdata = mem[bus.address];
    endcase
  end

  assign data_out_d = read_en ? rdata : data_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      out_q      <= '0;
    end else begin
      data_out_q <= data_out_d;
      out_q      <= out_d;
    end
  end

  // No reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (bus.write && region == REG_MEM) mem[bus.address] <= bus.data_in;
  end

  assign bus.data_out = data_out_q;
  assign output_pins  = out_q;
endmodule

// File: tb/tb_data_ram_mmio.sv
// Self-checking bench for data_ram_mmio: directed scenarios plus randomized traffic
// compared against an address-map level reference model.
module tb_data_ram_mmio;
  localparam int WORD     = 8;
  localparam int SIZE_LOG = 8;
  localparam int OUTPUT   = 5;
  localparam int INPUT    = 5;
  localparam int SYNC     = 2;
  localparam int SIZE     = 2 ** SIZE_LOG;
  localparam int LVL_B    = OUTPUT;
  localparam int EDG_B    = OUTPUT + INPUT;
  localparam int MEM_B    = OUTPUT + 2 * INPUT;

  logic              clk = 1'b0;
  logic              reset;
  logic [INPUT-1:0]  input_pins;
  logic [OUTPUT-1:0] output_pins;

  data_ram_mmio_if #(.WORD(WORD), .SIZE_LOG(SIZE_LOG)) bus ();

  data_ram_mmio #(
    .WORD        (WORD),
    .SIZE_LOG    (SIZE_LOG),
    .OUTPUT      (OUTPUT),
    .INPUT       (INPUT),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .input_pins  (input_pins),
    .output_pins (output_pins)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the address map should contain.
  logic [WORD-1:0]   mem_m [SIZE];
  logic [OUTPUT-1:0] out_m;
  logic [INPUT-1:0]  lvl_m;
  logic [INPUT-1:0]  flag_m;
  logic [WORD-1:0]   dout_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD-1:0] ref_read(input int a);
    logic [WORD-1:0] v;
    v = '0;
    if (a < LVL_B) v[0] = out_m[a];
    else if (a < EDG_B) v[0] = lvl_m[a - LVL_B];
    else if (a < MEM_B) v[0] = flag_m[a - EDG_B];
    else v = mem_m[a];
    return v;
  endfunction

  task automatic model_op(input logic wr, input logic rd, input int a, input logic [WORD-1:0] d);
    if (wr) begin
      if (a < LVL_B) out_m[a] = d[0];
      else if (a >= EDG_B && a < MEM_B) begin
        if (d[0]) flag_m[a - EDG_B] = 1'b0;
      end else if (a >= MEM_B) mem_m[a] = d;
    end else if (rd) begin
      dout_m = ref_read(a);
      if (a >= EDG_B && a < MEM_B) flag_m[a - EDG_B] = 1'b0;
    end
  endtask

  // Drive one bus cycle; returns #1 after the sampling edge.
  task automatic cycle(input logic wr, input logic rd, input int a, input logic [WORD-1:0] d);
    bus.write   = wr;
    bus.read    = rd;
    bus.address = SIZE_LOG'(a);
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic wr, input logic rd, input int a,
                          input logic [WORD-1:0] d);
    model_op(wr, rd, a, d);
    cycle(wr, rd, a, d);
    check({tag, "_dout"}, 32'(bus.data_out), 32'(dout_m));
    check({tag, "_pins"}, 32'(output_pins), 32'(out_m));
  endtask

  task automatic settle_pins(input logic [INPUT-1:0] p);
    input_pins = p;
    repeat (SYNC + 2) cycle(1'b0, 1'b0, 0, '0);
    flag_m = flag_m | (p & ~lvl_m);
    lvl_m  = p;
  endtask

  initial begin
    int first;
    reset = 1'b1;
    input_pins = '0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    out_m = '0; lvl_m = '0; flag_m = '0; dout_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = MEM_B; a < SIZE; a++) begin
      cycle(1'b1, 1'b0, a, '0);
      mem_m[a] = '0;
    end
    for (int a = 0; a < MEM_B; a++) mem_m[a] = '0;

    // Reset with pins and data_out non-zero beforehand.
    op_check("pre_w20", 1'b1, 1'b0, 20, 8'h5A);
    op_check("pre_r20", 1'b0, 1'b1, 20, '0);
    op_check("pre_w0", 1'b1, 1'b0, 0, 8'h01);
    op_check("pre_w4", 1'b1, 1'b0, 4, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("rst_pins", 32'(output_pins), 0);
    check("rst_dout", 32'(bus.data_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    out_m = '0; dout_m = '0; flag_m = '0;
    op_check("rst_read0", 1'b0, 1'b1, 0, '0);

    // Output pin write and readback.
    op_check("out_w2", 1'b1, 1'b0, 2, 8'h01);
    check("out_w2_lit", 32'(output_pins), 32'h04);
    op_check("out_r2", 1'b0, 1'b1, 2, '0);
    check("out_r2_lit", 32'(bus.data_out), 1);

    // Memory, read-while-write.
    op_check("mem_w20", 1'b1, 1'b0, 20, 8'hA5);
    op_check("mem_r20", 1'b0, 1'b1, 20, '0);
    check("mem_r20_lit", 32'(bus.data_out), 32'hA5);
    op_check("mem_rw20", 1'b1, 1'b1, 20, 8'h3C);
    check("mem_rw20_lit", 32'(bus.data_out), 32'hA5);
    op_check("mem_r20b", 1'b0, 1'b1, 20, '0);
    check("mem_r20b_lit", 32'(bus.data_out), 32'h3C);

    // Level latency on pin 1, then clear-on-read of its flag.
    input_pins[1] = 1'b1;
    first = 0;
    for (int k = 1; k <= SYNC + 3; k++) begin
      cycle(1'b0, 1'b1, LVL_B + 1, '0);
      if (first == 0 && bus.data_out[0]) first = k;
    end
    check("lvl_seen", 32'(first != 0), 1);
    check("lvl_not_early", 32'(first >= SYNC), 1);
    lvl_m[1] = 1'b1; flag_m[1] = 1'b1; dout_m = 8'h01;
    op_check("edg_r11", 1'b0, 1'b1, EDG_B + 1, '0);
    check("edg_r11_lit", 32'(bus.data_out), 1);
    op_check("edg_r11_clr", 1'b0, 1'b1, EDG_B + 1, '0);
    check("edg_r11_clr_lit", 32'(bus.data_out), 0);

    // Pin 3 edge landing on the same edge as a read of its flag: set wins.
    input_pins[3] = 1'b1;
    repeat (SYNC) cycle(1'b0, 1'b0, 0, '0);
    op_check("setwin_r13", 1'b0, 1'b1, EDG_B + 3, '0);
    flag_m[3] = 1'b1; lvl_m[3] = 1'b1;
    op_check("setwin_keep", 1'b0, 1'b1, EDG_B + 3, '0);
    check("setwin_keep_lit", 32'(bus.data_out), 1);
    settle_pins(input_pins & ~5'b01000);
    settle_pins(input_pins | 5'b01000);
    op_check("w1c_w13", 1'b1, 1'b0, EDG_B + 3, 8'h01);
    op_check("w1c_r13", 1'b0, 1'b1, EDG_B + 3, '0);
    check("w1c_r13_lit", 32'(bus.data_out), 0);

    // Reset clears flags, memory survives.
    settle_pins(5'b00001);
    op_check("keep_w30", 1'b1, 1'b0, 30, 8'h77);
    input_pins = '0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    out_m = '0; dout_m = '0; flag_m = '0; lvl_m = '0;
    op_check("rst_flag0", 1'b0, 1'b1, EDG_B, '0);
    check("rst_flag0_lit", 32'(bus.data_out), 0);
    op_check("rst_mem30", 1'b0, 1'b1, 30, '0);
    check("rst_mem30_lit", 32'(bus.data_out), 32'h77);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int op, a;
      logic [WORD-1:0] d;
      if (n % 50 == 0) settle_pins(INPUT'($urandom));
      op = $urandom_range(0, 3);
      a  = $urandom_range(0, 1) != 0 ? $urandom_range(0, MEM_B + 3) : $urandom_range(0, SIZE - 1);
      d  = WORD'($urandom);
      case (op)
        0: op_check("rnd_wr", 1'b1, 1'b0, a, d);
        1: op_check("rnd_rd", 1'b0, 1'b1, a, d);
        2: op_check("rnd_rw", 1'b1, 1'b1, a, d);
        default: op_check("rnd_idle", 1'b0, 1'b0, a, d);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
